// File: rtl/mult_arbiter.sv
// Two-port round-robin front end for one shift-add multiplier (one bit per clock).
// Define MULT_SAT_EN to saturate product to all ones on overflow instead of wrapping.
module mult_arbiter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] product,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e               state_q;
  logic                 last_q;
  logic                 owner_q;
  logic [2*WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]     mult_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [CntW-1:0]      cnt_q;

  logic                 win1;
  logic [2*WIDTH-1:0]   acc_sum;
  logic                 res_ovf;
  logic [WIDTH-1:0]     res;

  // On a tie the requester not served last wins.
  always_comb begin
    win1    = req1 & (~req0 | ~last_q);
    acc_sum = acc_q + (mult_q[0] ? mcand_q : '0);
    res_ovf = |acc_sum[2*WIDTH-1:WIDTH];
`ifdef MULT_SAT_EN
    res     = res_ovf ? '1 : acc_sum[WIDTH-1:0];
`else
    res     = acc_sum[WIDTH-1:0];
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      mcand_q <= '0;
      mult_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      product <= '0;
      ovf     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req0 | req1) begin
            owner_q <= win1;
            last_q  <= win1;
            mcand_q <= {{WIDTH{1'b0}}, (win1 ? a1 : a0)};
            mult_q  <= win1 ? b1 : b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            gnt0    <= ~win1;
            gnt1    <= win1;
            busy    <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          acc_q   <= acc_sum;
          mcand_q <= mcand_q << 1;
          mult_q  <= mult_q >> 1;
          cnt_q   <= cnt_q + CntW'(1);
          // Result registers take the sum including this last iteration's add.
          if (cnt_q == CntMax) begin
            product <= res;
            ovf     <= res_ovf;
            done0   <= ~owner_q;
            done1   <= owner_q;
            state_q <= StDone;
          end
        end
        StDone: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: vector table, corner sequences, randomized ops.
module tb_mult_arbiter;
  localparam int W = 32;

  logic          clk, rst, req0, req1;
  logic [W-1:0]  a0, b0, a1, b1;
  logic          gnt0, gnt1, done0, done1, ovf, busy;
  logic [W-1:0]  product;

  int checks = 0;
  int errors = 0;
  int last_served = 1;

  mult_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .product(product), .ovf(ovf), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          port;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] prod;
    bit          ovf;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: full-width product from plain arithmetic.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] p, output bit o);
    logic [63:0] f;
    f = {32'b0, a} * {32'b0, b};
    o = (f[63:32] != 32'b0);
    p = f[31:0];
`ifdef MULT_SAT_EN
    if (o) p = 32'hFFFF_FFFF;
`endif
  endfunction

  function automatic int pick(input bit r0, input bit r1);
    if (r0 && !r1) return 0;
    if (r1 && !r0) return 1;
    return (last_served == 1) ? 0 : 1;
  endfunction

  task automatic wait_grant(input string tag, output int who, output int n);
    who = -1;
    n   = 0;
    while (who < 0 && n < 100) begin
      @(negedge clk);
      n++;
      if (gnt0 | gnt1) who = gnt1 ? 1 : 0;
    end
    if (who < 0) check({tag, "_grant_timeout"}, 0, 1);
    else check({tag, "_gnt_onehot"}, {gnt1, gnt0}, (who == 1) ? 2'b10 : 2'b01);
  endtask

  // n counts negedges from the grant sample edge; the grant negedge is n=1.
  task automatic wait_done(input string tag, input int who, input logic [31:0] exp_p,
                           input bit exp_o, input int raise1_at);
    int n;
    bit seen;
    bit stray;
    n = 1;
    seen = 0;
    stray = 0;
    while (!seen && n < W + 20) begin
      @(negedge clk);
      n++;
      if (n == raise1_at) req1 = 1'b1;
      if (done0 | done1) seen = 1;
      else if (gnt0 | gnt1) stray = 1;
    end
    if (!seen) begin
      check({tag, "_done_timeout"}, 0, 1);
    end else begin
      check({tag, "_latency"}, n, W + 1);
      check({tag, "_done_owner"}, {done1, done0}, (who == 1) ? 2'b10 : 2'b01);
      check({tag, "_busy_in_done"}, busy, 1);
      check({tag, "_product"}, product, exp_p);
      check({tag, "_ovf"}, ovf, exp_o);
    end
    check({tag, "_gnt_while_busy"}, stray, 0);
    @(negedge clk);
    check({tag, "_idle_after"}, {done1, done0, busy}, 3'b000);
  endtask

  task automatic drive(input bit port, input logic [31:0] a, input logic [31:0] b);
    if (port) begin req1 = 1'b1; a1 = a; b1 = b; end
    else      begin req0 = 1'b1; a0 = a; b0 = b; end
  endtask

  vec_t vecs[6];

  initial begin
    int who, n, exp_who, cnt;
    bit r0, r1, eo;
    logic [31:0] ra, rb, ep;

    vecs[0] = '{0, 32'd3, 32'd5, 32'd15, 0};
`ifdef MULT_SAT_EN
    vecs[1] = '{1, 32'h0001_0000, 32'h0001_0000, 32'hFFFF_FFFF, 1};
    vecs[5] = '{0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1};
`else
    vecs[1] = '{1, 32'h0001_0000, 32'h0001_0000, 32'h0, 1};
    vecs[5] = '{0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 1};
`endif
    vecs[2] = '{0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 0};
    vecs[3] = '{0, 32'd0, 32'hFFFF_FFFF, 32'd0, 0};
    vecs[4] = '{1, 32'd7, 32'd9, 32'd63, 0};

    rst = 1'b0; req0 = 0; req1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    repeat (2) @(negedge clk);
    check("reset_pulses", {gnt1, gnt0, done1, done0, busy, ovf}, 6'b0);
    check("reset_product", product, 0);
    rst = 1'b1;
    last_served = 1;

    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].port, vecs[i].a, vecs[i].b);
      wait_grant("vec", who, n);
      check("vec_owner", who, vecs[i].port);
      check("vec_gnt_latency", n, 1);
      check("vec_busy_rise", busy, 1);
      req0 = 0; req1 = 0;
      last_served = vecs[i].port;
      wait_done("vec", vecs[i].port, vecs[i].prod, vecs[i].ovf, -1);
    end

    // req1 raised mid-operation must wait until IDLE, then win at the earliest edge.
    a1 = 32'd5; b1 = 32'd6;
    drive(0, 32'd2, 32'd21);
    wait_grant("busy_ign", who, n);
    check("busy_ign_owner", who, 0);
    req0 = 0;
    last_served = 0;
    wait_done("busy_ign", 0, 32'd42, 0, 4);
    wait_grant("busy_ign_late", who, n);
    check("busy_ign_late_owner", who, 1);
    check("busy_ign_late_edge", n, 1);
    req1 = 0;
    last_served = 1;
    wait_done("busy_ign_late", 1, 32'd30, 0, -1);

    // Reset in the middle of RUN aborts the operation silently.
    drive(0, 32'd3, 32'd5);
    wait_grant("midrst", who, n);
    req0 = 0;
    repeat (9) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_pulses", {gnt1, gnt0, done1, done0, busy, ovf}, 6'b0);
    check("midrst_product", product, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    last_served = 1;
    cnt = 0;
    repeat (W + 5) begin
      @(negedge clk);
      if (done0 | done1 | gnt0 | gnt1 | busy) cnt++;
    end
    check("midrst_no_done", cnt, 0);
    drive(0, 32'd3, 32'd5);
    wait_grant("postrst", who, n);
    check("postrst_owner", who, 0);
    check("postrst_gnt_latency", n, 1);
    req0 = 0;
    last_served = 0;
    wait_done("postrst", 0, 32'd15, 0, -1);

    // Both held high from reset: grants must alternate 0,1,0,1.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    last_served = 1;
    a0 = 32'd7; b0 = 32'd9; a1 = 32'h10; b1 = 32'h10;
    req0 = 1; req1 = 1;
    for (int k = 0; k < 4; k++) begin
      exp_who = pick(1, 1);
      wait_grant("rr", who, n);
      check("rr_owner", who, exp_who);
      check("rr_gnt_edge", n, 1);
      last_served = exp_who;
      if (k == 3) begin req0 = 0; req1 = 0; end
      wait_done("rr", exp_who, (exp_who == 1) ? 32'h100 : 32'd63, 0, -1);
    end

    for (int k = 0; k < 16; k++) begin
      r0 = 0; r1 = 0;
      case ($urandom_range(1, 3))
        1: r0 = 1;
        2: r1 = 1;
        default: begin r0 = 1; r1 = 1; end
      endcase
      ra = $urandom; rb = $urandom;
      if ($urandom_range(0, 1) == 1) begin ra &= 32'hFFFF; rb &= 32'hFFFF; end
      if (r0) drive(0, ra, rb);
      if (r1) drive(1, ~ra, rb ^ 32'h5A5A);
      exp_who = pick(r0, r1);
      wait_grant("rnd", who, n);
      check("rnd_owner", who, exp_who);
      req0 = 0; req1 = 0;
      last_served = exp_who;
      if (exp_who == 1) model(~ra, rb ^ 32'h5A5A, ep, eo);
      else model(ra, rb, ep, eo);
      wait_done("rnd", exp_who, ep, eo, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Shares one iterative shift-add multiplier between two requesters: keyboard-driven operand entry (port 0) and tick-driven game/display logic (port 1). It arbitrates round-robin, sequences the multiply one bit per clock, and returns a single-width product plus an overflow flag to whichever requester was granted. It sits between the operand sources in the top level and the `product` bus that feeds the draw logic.

## Interface
- `WIDTH`, 32, operand and product width in bits.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req0`, `req1`  in  1  level request; held until the matching `gnt` is seen.
- `a0`, `b0`, `a1`, `b1`  in  WIDTH  operands; must be stable while the matching `req` is high.
- `gnt0`, `gnt1`  out  1  one-cycle pulse; operands were captured at the previous edge.
- `done0`, `done1`  out  1  one-cycle pulse; `product` and `ovf` are valid for that owner.
- `product`  out  WIDTH  result of the last completed operation; held until the next completion.
- `ovf`  out  1  the true 2·WIDTH product did not fit in WIDTH bits; held with `product`.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States:
  - IDLE: arbitrate.
  - RUN: WIDTH iterations.
  - DONE: one-cycle result strobe; returns to IDLE.
- Arbitration in IDLE:
  - If exactly one `req` is high, that requester wins.
  - If both are high, the requester not served last wins.
  - The `last` register resets to 1, so `req0` wins the first tie.
  - `last` updates at each grant.
- Grant edge:
  - Capture `a` into a 2·WIDTH multiplicand register (zero-extended) and `b` into a WIDTH multiplier register.
  - Clear the 2·WIDTH accumulator and the iteration counter.
  - Record the owner; enter RUN.
- RUN, each edge:
  - If mult[0] is 1, acc += mcand.
  - Then mcand <<= 1, mult >>= 1, cnt += 1.
  - After exactly WIDTH iterations, go to DONE. There is no early exit for zero operands.
- Completion (RUN→DONE edge):
  - `product` ← acc[WIDTH-1:0].
  - `ovf` ← OR of acc[2·WIDTH-1:WIDTH].
  - The final iteration's add is included in this result.
- DONE: `done<owner>` high for one cycle, then IDLE.
- Requests arriving while busy are ignored until IDLE. A requester that keeps `req` high after its `gnt` is granted again, subject to round-robin.
- `gnt` and `done` pulses go only to the owner; the other requester's outputs stay 0.
- Reset (any state, including mid-RUN):
  - Immediately: state = IDLE, all `gnt`/`done`/`busy` = 0, `product` = 0, `ovf` = 0, `last` = 1, internal registers cleared.
  - The aborted operation produces no `done`.

## Timing
- Edge E0 samples `req` in IDLE. `gnt` is high in cycle E0+1, and `busy` rises in the same cycle.
- RUN takes edges E0+1 … E0+WIDTH. `product`/`ovf` update at edge E0+WIDTH.
- `done` is high for the cycle following edge E0+WIDTH, with `busy` still 1.
- IDLE is re-entered at edge E0+WIDTH+1. The earliest next grant edge is E0+WIDTH+2, giving a throughput of one multiply per WIDTH+2 cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `MULT_SAT_EN` defined:
  - When overflow occurs, `product` is forced to all ones (0xFFFFFFFF for WIDTH=32).
  - `ovf` is still reported.
- `MULT_SAT_EN` undefined:
  - `product` is the low WIDTH bits (wrap-around).
  - `ovf` is still reported.

## Test plan
- Reset low mid-RUN (cycle 10), then release → all outputs 0 immediately, no `done`, next `req0` is granted normally.
- `req0` with a0=3, b0=5 → `gnt0` one cycle after the sample edge, `done0` WIDTH+1 edges after the sample edge, `product`=15, `ovf`=0.
- `req0` and `req1` rise together and both stay high → grants alternate 0,1,0,1 with no starvation; each `done` matches its owner's operands (a0·b0=7·9=63, a1·b1=0x10·0x10=0x100).
- `req1` with a1=0x10000, b1=0x10000 → `ovf`=1 and `product`=0; with `MULT_SAT_EN` defined, `product`=0xFFFFFFFF.
- `req0` with a0=0xFFFFFFFF, b0=1 → `product`=0xFFFFFFFF, `ovf`=0; a0=0, b0=0xFFFFFFFF → `product`=0, full WIDTH-cycle latency unchanged.
- `req1` asserted while busy serving `req0` → ignored until IDLE, then granted at the earliest edge (E0+WIDTH+2).
